ttl86_xor_quad: RTL and testbench

- Clocked model of a 74LS86 quad 2-input XOR gate.
- Four independent gates; output Yn = An XOR Bn.
- Propagation delay is modelled as a fixed clock-cycle latency.
- Used as a drop-in TTL part in the Manchester Baby TTL netlist.

---
 rtl/ttl86_pkg.sv | 9 +
 rtl/ttl86_xor_cell.sv | 67 ++++++
 rtl/ttl86_xor_quad.sv | 70 +++++++
 tb/tb_ttl86_xor_quad.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl86_pkg.sv
// Shared constants for the ttl86_xor_quad clocked 74LS86 model.
package ttl86_pkg;

    localparam int unsigned NUM_GATES            = 4;
    localparam int unsigned DEFAULT_DELAY_CYCLES = 2;
    localparam int unsigned MAX_DELAY_CYCLES     = 4;
    localparam int unsigned TOG_WIDTH            = 8;

endpackage

// File: rtl/ttl86_xor_cell.sv
// One XOR gate with a DELAY_CYCLES-deep output delay line.
// TTL86_TOGGLE_COUNT_EN adds a saturating output toggle counter.
module ttl86_xor_cell
    import ttl86_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = DEFAULT_DELAY_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 b,
    output logic                 y
`ifdef TTL86_TOGGLE_COUNT_EN
    ,
    output logic [TOG_WIDTH-1:0] tog
`endif
);

    generate
        if (DELAY_CYCLES == 0 || DELAY_CYCLES > MAX_DELAY_CYCLES) begin : g_bad_delay
            $error("ttl86_xor_cell: DELAY_CYCLES must be in 1..%0d", MAX_DELAY_CYCLES);
        end
    endgenerate

    logic [DELAY_CYCLES-1:0] pipe_q;
    logic [DELAY_CYCLES-1:0] pipe_d;

    // Bit 0 is the freshly sampled result; the top bit drives y.
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = a ^ b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign y = pipe_q[DELAY_CYCLES-1];

`ifdef TTL86_TOGGLE_COUNT_EN
    logic [TOG_WIDTH-1:0] tog_q;
    logic [TOG_WIDTH-1:0] tog_d;

    // Count on the edge where y changes, so the count tracks y without lag.
    always_comb begin
        tog_d = tog_q;
        if ((pipe_d[DELAY_CYCLES-1] != pipe_q[DELAY_CYCLES-1]) && (tog_q != '1)) begin
            tog_d = tog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign tog = tog_q;
`endif

endmodule

// File: rtl/ttl86_xor_quad.sv
// Clocked 74LS86 quad 2-input XOR with fixed DELAY_CYCLES latency.
// Define TTL86_TOGGLE_COUNT_EN to add per-gate toggle counters TOG1..TOG4.
module ttl86_xor_quad
    import ttl86_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = DEFAULT_DELAY_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 A1,
    input  logic                 B1,
    output logic                 Y1,
    input  logic                 A2,
    input  logic                 B2,
    output logic                 Y2,
    input  logic                 A3,
    input  logic                 B3,
    output logic                 Y3,
    input  logic                 A4,
    input  logic                 B4,
    output logic                 Y4
`ifdef TTL86_TOGGLE_COUNT_EN
    ,
    output logic [TOG_WIDTH-1:0] TOG1,
    output logic [TOG_WIDTH-1:0] TOG2,
    output logic [TOG_WIDTH-1:0] TOG3,
    output logic [TOG_WIDTH-1:0] TOG4
`endif
);

    logic [NUM_GATES-1:0] a_vec;
    logic [NUM_GATES-1:0] b_vec;
    logic [NUM_GATES-1:0] y_vec;

    assign a_vec = {A4, A3, A2, A1};
    assign b_vec = {B4, B3, B2, B1};

`ifdef TTL86_TOGGLE_COUNT_EN
    logic [TOG_WIDTH-1:0] tog_vec [NUM_GATES];
`endif

    for (genvar g = 0; g < int'(NUM_GATES); g++) begin : g_gate
        ttl86_xor_cell #(
            .DELAY_CYCLES(DELAY_CYCLES)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .a    (a_vec[g]),
            .b    (b_vec[g]),
            .y    (y_vec[g])
`ifdef TTL86_TOGGLE_COUNT_EN
            ,
            .tog  (tog_vec[g])
`endif
        );
    end

    assign Y1 = y_vec[0];
    assign Y2 = y_vec[1];
    assign Y3 = y_vec[2];
    assign Y4 = y_vec[3];

`ifdef TTL86_TOGGLE_COUNT_EN
    assign TOG1 = tog_vec[0];
    assign TOG2 = tog_vec[1];
    assign TOG3 = tog_vec[2];
    assign TOG4 = tog_vec[3];
`endif

endmodule

// File: tb/tb_ttl86_xor_quad.sv
// Self-checking bench for ttl86_xor_quad against a sample-history reference model.
module tb_ttl86_xor_quad;

    localparam int unsigned DLY = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       y1, y2, y3, y4;
    logic [3:0] y;

    assign y = {y4, y3, y2, y1};

`ifdef TTL86_TOGGLE_COUNT_EN
    logic [7:0] tog1, tog2, tog3, tog4;
`endif

    always #5 clk = ~clk;

    ttl86_xor_quad #(
        .DELAY_CYCLES(DLY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A1   (a[0]),
        .B1   (b[0]),
        .Y1   (y1),
        .A2   (a[1]),
        .B2   (b[1]),
        .Y2   (y2),
        .A3   (a[2]),
        .B3   (b[2]),
        .Y3   (y3),
        .A4   (a[3]),
        .B4   (b[3]),
        .Y4   (y4)
`ifdef TTL86_TOGGLE_COUNT_EN
        ,
        .TOG1 (tog1),
        .TOG2 (tog2),
        .TOG3 (tog3),
        .TOG4 (tog4)
`endif
    );

    int nvec = 0;
    int nmis = 0;

    // Reference model: history of sampled inputs; output = XOR of the sample DLY-1 edges ago.
    logic [3:0] hist_a[$];
    logic [3:0] hist_b[$];
    logic [3:0] exp_y;
    int         exp_tog[4];

`ifdef TTL86_TOGGLE_COUNT_EN
    function automatic int tog_obs(input int g);
        case (g)
            0:       return int'(tog1);
            1:       return int'(tog2);
            2:       return int'(tog3);
            default: return int'(tog4);
        endcase
    endfunction
`endif

    task automatic model_reset();
        hist_a.delete();
        hist_b.delete();
        for (int i = 0; i < int'(DLY); i++) begin
            hist_a.push_back(4'b0);
            hist_b.push_back(4'b0);
        end
        exp_y = 4'b0;
        for (int g = 0; g < 4; g++) exp_tog[g] = 0;
    endtask

    // Drive one input pair at a negedge, let one rising edge sample it, return at the next negedge.
    task automatic step(input logic [3:0] na, input logic [3:0] nb);
        logic [3:0] nxt;
        a = na;
        b = nb;
        @(posedge clk);
        hist_a.push_back(na);
        hist_b.push_back(nb);
        if (hist_a.size() > 8) begin
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
        end
        nxt = hist_a[hist_a.size() - DLY] ^ hist_b[hist_b.size() - DLY];
        for (int g = 0; g < 4; g++) begin
            if (nxt[g] != exp_y[g] && exp_tog[g] < 255) exp_tog[g]++;
        end
        exp_y = nxt;
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] na, input logic [3:0] nb, input int n);
        for (int i = 0; i < n; i++) step(na, nb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 4'b0;
        b     = 4'b0;
        model_reset();
        #12;
        nvec++;
        if (y !== 4'b0) begin
            nmis++;
            $display("FAIL reset_init: Y=%b expected 0000", y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'hF, 4'h0, DLY + 1);
        nvec++;
        if (y !== 4'hF) begin
            nmis++;
            $display("FAIL pre_reset_ones: Y=%b expected 1111", y);
        end
        // Assert reset between edges with ones in flight; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (y !== 4'b0) begin
            nmis++;
            $display("FAIL reset_async: Y=%b expected 0000", y);
        end
`ifdef TTL86_TOGGLE_COUNT_EN
        for (int g = 0; g < 4; g++) begin
            nvec++;
            if (tog_obs(g) != 0) begin
                nmis++;
                $display("FAIL reset_tog%0d: TOG=%0d expected 0", g + 1, tog_obs(g));
            end
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= int'(DLY); i++) begin
            step(4'hF, 4'h0);
            nvec++;
            if (y !== ((i == int'(DLY)) ? 4'hF : 4'h0) || y !== exp_y) begin
                nmis++;
                $display("FAIL post_reset_edge%0d: Y=%b expected %b", i, y, exp_y);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] ca;
        logic [3:0] cb;
        logic [1:0] p;
        logic [3:0] want;
        ca = 4'b0;
        cb = 4'b0;
        hold(ca, cb, DLY + 1);
        for (int g = 0; g < 4; g++) begin
            for (int pi = 0; pi < 4; pi++) begin
                p     = 2'(pi);
                ca[g] = p[1];
                cb[g] = p[0];
                hold(ca, cb, DLY + 1);
                want  = 4'((p[1] ^ p[0]) ? (1 << g) : 0);
                nvec++;
                if (y !== want || y !== exp_y) begin
                    nmis++;
                    $display("FAIL exhaustive_g%0d_ab%b: Y=%b expected %b", g + 1, p, y, want);
                end
            end
        end
    endtask

    task automatic test_mixed();
        logic [3:0] va[3];
        logic [3:0] vb[3];
        logic [3:0] vy[3];
        va[0] = 4'b0101; vb[0] = 4'b0110; vy[0] = 4'b0011;
        va[1] = 4'b1010; vb[1] = 4'b0110; vy[1] = 4'b1100;
        va[2] = 4'b1111; vb[2] = 4'b1111; vy[2] = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            hold(va[i], vb[i], DLY + 1);
            nvec++;
            if (y !== vy[i] || y !== exp_y) begin
                nmis++;
                $display("FAIL mixed_%0d: Y=%b expected %b", i, y, vy[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic want;
        hold(4'b0, 4'b0, DLY + 1);
        for (int i = 0; i <= int'(DLY); i++) begin
            step(4'b0001, 4'b0);
            want = (i >= int'(DLY) - 1);
            nvec++;
            if (y1 !== want || y !== exp_y) begin
                nmis++;
                $display("FAIL latency_edge_k+%0d: Y1=%b expected %b", i, y1, want);
            end
        end
    endtask

    task automatic test_glitch();
        hold(4'b0000, 4'b0001, DLY + 1);
        for (int i = 0; i < int'(DLY) + 2; i++) begin
            step(4'b0001, 4'b0000);
            nvec++;
            if (y1 !== 1'b1) begin
                nmis++;
                $display("FAIL glitch_swap_cycle%0d: Y1=%b expected 1", i, y1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step(4'($urandom), 4'($urandom));
            nvec++;
            if (y !== exp_y) begin
                nmis++;
                $display("FAIL random_%0d: Y=%b expected %b", i, y, exp_y);
            end
`ifdef TTL86_TOGGLE_COUNT_EN
            for (int g = 0; g < 4; g++) begin
                if (tog_obs(g) != exp_tog[g]) begin
                    nvec++;
                    nmis++;
                    $display("FAIL random_tog%0d_%0d: TOG=%0d expected %0d",
                             g + 1, i, tog_obs(g), exp_tog[g]);
                end
            end
`endif
        end
    endtask

`ifdef TTL86_TOGGLE_COUNT_EN
    task automatic test_toggle();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(4'((i % 2 == 0) ? 4'b0010 : 4'b0000), 4'b0);
            if (i == 20) begin
                nvec++;
                if (int'(tog2) != exp_tog[1]) begin
                    nmis++;
                    $display("FAIL toggle_mid: TOG2=%0d expected %0d", tog2, exp_tog[1]);
                end
            end
        end
        nvec++;
        if (tog2 !== 8'd255) begin
            nmis++;
            $display("FAIL toggle_sat: TOG2=%0d expected 255", tog2);
        end
        nvec++;
        if (tog1 !== 8'd0 || tog3 !== 8'd0 || tog4 !== 8'd0) begin
            nmis++;
            $display("FAIL toggle_others: TOG1=%0d TOG3=%0d TOG4=%0d expected 0", tog1, tog3, tog4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exhaustive();
        test_mixed();
        test_latency();
        test_glitch();
        test_random();
`ifdef TTL86_TOGGLE_COUNT_EN
        test_toggle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
